// File: rtl/ascon_serial_host_if.sv
// ascon_serial_host_if: job-in / result-out handshake bundle between a bus front end (master) and ascon_serial_host (slave)
interface ascon_serial_host_if #(
  parameter int K = 128,
  parameter int L = 32,
  parameter int Y = 32
);
  logic job_valid, job_ready;
  logic [K-1:0] key_i;
  logic [127:0] nonce_i;
  logic [L-1:0] ad_i;
  logic [Y-1:0] pt_i;
  logic res_valid, res_ready;
  logic [Y-1:0] ct_o;
  logic [127:0] tag_o;
  logic err_o;
  modport master (
    output job_valid, key_i, nonce_i, ad_i, pt_i, res_ready,
    input  job_ready, res_valid, ct_o, tag_o, err_o
  );
  modport slave (
    input  job_valid, key_i, nonce_i, ad_i, pt_i, res_ready,
    output job_ready, res_valid, ct_o, tag_o, err_o
  );
endinterface

// File: rtl/ascon_serial_host.sv
// ascon_serial_host: drives one parallel job MSB-first into the bit-serial Ascon core and collects the LSB-first ct/tag
// Ports: clk, rst (async, active-high); bus = job_valid/job_ready + key/nonce/ad/pt in, res_valid/res_ready + ct/tag/err out;
// core_rst, *xSI lanes (bit0 data share, bits 4:1 random shares), r_*xSI random lanes and starts to the core;
// cipher_textxSO, tagxSO, encryption_readyxSO from the core.
// Define ASCON_SERIAL_HOST_MASK_EN to feed the random shares from a 32-bit Galois LFSR; otherwise they are tied to 0.
module ascon_serial_host #(
  parameter int K = 128,
  parameter int L = 32,
  parameter int Y = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  ascon_serial_host_if.slave bus,
  output logic core_rst,
  output logic [4:0] keyxSI,
  output logic [4:0] noncexSI,
  output logic [4:0] associated_dataxSI,
  output logic [4:0] plain_textxSI,
  output logic [13:0] r_64xSI,
  output logic [2:0] r_128xSI,
  output logic [2:0] r_ptxSI,
  output logic encryption_startxSI,
  output logic decryption_startxSI,
  input  logic cipher_textxSO,
  input  logic tagxSO,
  input  logic encryption_readyxSO
);
  localparam int M1 = K > 128 ? K : 128;
  localparam int M2 = L > Y ? L : Y;
  localparam int SLEN = (M1 > M2 ? M1 : M2) + 2;
  localparam int CLEN = Y > 128 ? Y : 128;
  localparam int CW = $clog2(SLEN > TIMEOUT ? SLEN : TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, CRST, SHIFT, START, COLLECT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [K-1:0] key_sr;
  logic [127:0] nonce_sr;
  logic [L-1:0] ad_sr;
  logic [Y-1:0] pt_sr, ct_r;
  logic [127:0] tag_r;
  logic err_r, sh;
  logic [31:0] rnd;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.job_valid ? CRST : IDLE;
      CRST:    nxt = SHIFT;
      SHIFT:   nxt = cnt == CW'(SLEN - 1) ? START : SHIFT;
      START:   nxt = encryption_readyxSO ? COLLECT : cnt == CW'(TIMEOUT - 1) ? DONE : START;
      COLLECT: nxt = cnt == CW'(CLEN - 1) ? DONE : COLLECT;
      DONE:    nxt = bus.res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // one counter serves as shift beat, watchdog and collect index; it restarts on every state change
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      key_sr <= '0;
      nonce_sr <= '0;
      ad_sr <= '0;
      pt_sr <= '0;
      ct_r <= '0;
      tag_r <= '0;
      err_r <= 1'b0;
    end else begin
      cnt <= (state == nxt && state inside {SHIFT, START, COLLECT}) ? cnt + 1'b1 : '0;
      if (state == IDLE && bus.job_valid) begin
        key_sr <= bus.key_i;
        nonce_sr <= bus.nonce_i;
        ad_sr <= bus.ad_i;
        pt_sr <= bus.pt_i;
        ct_r <= '0;
        tag_r <= '0;
        err_r <= 1'b0;
      end
      // zeros shift in behind each field, so beats past its width carry 0
      if (state == SHIFT) begin
        key_sr <= key_sr << 1;
        nonce_sr <= nonce_sr << 1;
        ad_sr <= ad_sr << 1;
        pt_sr <= pt_sr << 1;
      end
      // right shift: after n samples the first serial bit lands in bit 0
      if (state == COLLECT && cnt < CW'(Y)) ct_r <= {cipher_textxSO, ct_r[Y-1:1]};
      if (state == COLLECT && cnt < CW'(128)) tag_r <= {tagxSO, tag_r[127:1]};
      if (state == START && nxt == DONE && !encryption_readyxSO) err_r <= 1'b1;
    end
`ifdef ASCON_SERIAL_HOST_MASK_EN
  localparam logic [31:0] POLY = 32'h8020_0003;
  logic [31:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 32'hACE1_0001;
    else lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0);
  assign rnd = state == IDLE ? 32'h0 : lfsr;
`else
  assign rnd = 32'h0;
`endif
  // random taps: key [3:0], nonce [7:4], ad [11:8], pt [15:12], r_64 [29:16], r_128 [31:29], r_pt [18:16]^[31:29]
  assign sh = state == SHIFT;
  assign keyxSI = {rnd[3:0], sh & key_sr[K-1]};
  assign noncexSI = {rnd[7:4], sh & nonce_sr[127]};
  assign associated_dataxSI = {rnd[11:8], sh & ad_sr[L-1]};
  assign plain_textxSI = {rnd[15:12], sh & pt_sr[Y-1]};
  assign r_64xSI = rnd[29:16];
  assign r_128xSI = rnd[31:29];
  assign r_ptxSI = rnd[18:16] ^ rnd[31:29];
  assign core_rst = state == CRST;
  assign encryption_startxSI = state inside {START, COLLECT};
  assign decryption_startxSI = 1'b0;
  assign bus.job_ready = state == IDLE;
  assign bus.res_valid = state == DONE;
  assign bus.ct_o = ct_r;
  assign bus.tag_o = tag_r;
  assign bus.err_o = err_r;
endmodule
